vote_collector: RTL
===================

Name: vote_collector

Overview:
- Sequential front end for the 4-voter majority block.
- Opens a timed ballot session and collects one ballot from each of four stations over a per-station req/ack handshake.
- Publishes the 4-bit ballot vector (bit i = station i, 1 = yes) with a one-cycle valid strobe; the combinational majority decoder consumes the vector.
- Enforces one vote per station per session, and closes the session on completion or on window timeout.

Parameters:
- WINDOW_CYC, 1000: session length in clk cycles from session open to forced close; legal range 2..65535.
- HOLD_CYC, 16: cycles the published ballot is held, with busy asserted, before returning to idle; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  open a session; sampled in IDLE only
- vote_req  input  4  per-station vote request, level
- vote_val  input  4  per-station ballot value, sampled with vote_req
- vote_ack  output  4  per-station accept pulse, one cycle
- ballot  output  4  collected ballot vector to the majority decoder
- ballot_valid  output  1  one-cycle strobe: ballot is final
- timeout  output  1  set at publish if the window expired; holds until the next session opens
- busy  output  1  high from session open to return to IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - vote_ack, ballot, ballot_valid, timeout and busy all 0.
  - Internal voted mask and counters cleared.
- IDLE:
  - busy=0; ballot and timeout hold their last values.
  - start=1 moves to OPEN next cycle. On that edge: ballot=0, voted=0, timeout=0, window counter=WINDOW_CYC-1.
- OPEN:
  - busy=1; window counter decrements each cycle.
  - Station i is accepted when vote_req[i]=1 and voted[i]=0. On acceptance: ballot[i]<=vote_val[i], voted[i]<=1, and vote_ack[i]=1 on the following cycle only.
  - Any number of stations can be accepted in the same cycle.
  - Requests from stations already voted are ignored: no ack, ballot unchanged.
  - When voted reaches 4'b1111, go to PUBLISH next cycle. This includes the case where the final vote(s) arrive in that cycle.
  - When the window counter is 0 and voted is not full, go to PUBLISH with timeout=1. Unvoted stations stay 0 (abstain counts as no).
  - Last vote accepted in the same cycle the counter reaches 0: the vote counts and timeout=0.
- PUBLISH:
  - Exactly one cycle with ballot_valid=1 and ballot final.
  - Then HOLD.
  - ballot_valid is 0 in every other state.
- HOLD:
  - ballot held stable for HOLD_CYC cycles, busy=1, vote_req ignored.
  - Then IDLE.
- Latency:
  - All four stations request in the first OPEN cycle: acks the next cycle, ballot_valid 2 cycles after the requests.
- start is ignored outside IDLE; no session restart.
- rst_n asserted mid-session aborts immediately to the reset values; no publish.
- vote_ack is registered; there is no combinational path from any input to any output.

Optional Feature:
- Macro: VOTE_COUNT_EN.
- Defined: adds output vote_cnt [2:0], the number of stations accepted in the current session.
  - Cleared on session open and on reset.
  - Incremented by the number of same-cycle acceptances (0..4).
  - Held through PUBLISH, HOLD and IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then start, then vote_req=4'b1111 with vote_val=4'b1011 in one cycle -> vote_ack=4'b1111 next cycle; ballot_valid=1 one cycle later with ballot=4'b1011, timeout=0; busy falls HOLD_CYC+1 cycles after ballot_valid.
- Sequential votes: station 0 votes 1, then 1 votes 0, then 2 votes 1, then 3 votes 1, each a cycle apart -> four single-bit acks; ballot=4'b1101 at ballot_valid.
- Duplicate: station 2 requests with vote_val=1, then again with vote_val=0 -> a single ack only; ballot[2]=1.
- Timeout with WINDOW_CYC=8: only station 1 votes 1 -> ballot_valid on cycle 9 after session open, ballot=4'b0010, timeout=1.
- Edge timing: last station votes in the cycle the counter reaches 0 -> timeout=0, ballot complete. Separately, start pulsed during HOLD -> ignored.
- Reset mid-OPEN after 2 acks -> all outputs 0 and no ballot_valid. The next session collects cleanly; with VOTE_COUNT_EN defined, vote_cnt=4 at publish.

Source files
------------

// File: rtl/vote_collector.sv
// Sequential ballot collector that feeds the 4-voter majority decoder.
// Optional build macro VOTE_COUNT_EN adds the vote_cnt output.
module vote_collector #(
   parameter int WINDOW_CYC = 1000,
   parameter int HOLD_CYC   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] vote_req,
   input  logic [3:0] vote_val,
   output logic [3:0] vote_ack,
   output logic [3:0] ballot,
   output logic       ballot_valid,
   output logic       timeout,
   output logic       busy
`ifdef VOTE_COUNT_EN
   ,
   output logic [2:0] vote_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_OPEN,
      S_PUBLISH,
      S_HOLD
   } state_t;

   localparam logic [15:0] WIN_LOAD  = 16'(WINDOW_CYC - 1);
   localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYC - 1);

   state_t      state, state_next;
   logic [15:0] win_cnt;
   logic [7:0]  hold_cnt;
   logic [3:0]  voted;
   logic [3:0]  accept;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      accept     = '0;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_OPEN;
         end
         S_OPEN: begin
            accept = vote_req & ~voted;
            // A full mask publishes on the following edge; expiry publishes whatever is in.
            if (&voted || win_cnt == 16'd0) state_next = S_PUBLISH;
         end
         S_PUBLISH: state_next = S_HOLD;
         S_HOLD: begin
            if (hold_cnt == 8'd0) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         win_cnt  <= '0;
         hold_cnt <= '0;
         voted    <= '0;
         ballot   <= '0;
         timeout  <= 1'b0;
         vote_ack <= '0;
      end else begin
         state    <= state_next;
         vote_ack <= accept;
         case (state)
            S_IDLE: begin
               if (start) begin
                  ballot  <= '0;
                  voted   <= '0;
                  timeout <= 1'b0;
                  win_cnt <= WIN_LOAD;
               end
            end
            S_OPEN: begin
               win_cnt <= win_cnt - 16'd1;
               ballot  <= (ballot & ~accept) | (vote_val & accept);
               voted   <= voted | accept;
               // A vote landing on the final window cycle still completes the ballot.
               if (win_cnt == 16'd0 && !(&voted)) timeout <= ~&(voted | accept);
            end
            S_PUBLISH: hold_cnt <= HOLD_LOAD;
            S_HOLD:    hold_cnt <= hold_cnt - 8'd1;
            default: ;
         endcase
      end
   end

   assign ballot_valid = (state == S_PUBLISH);
   assign busy         = (state != S_IDLE);

`ifdef VOTE_COUNT_EN
   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vote_cnt <= '0;
      end else if (state == S_IDLE && start) begin
         vote_cnt <= '0;
      end else if (state == S_OPEN) begin
         vote_cnt <= vote_cnt + popcount4(accept);
      end
   end
`endif

endmodule
